icache_stream_prefetcher: RTL

Parametrised next-generation icache prefetch engine. On each accepted icache miss it generates PREF_DEGREE sequential next-line prefetch requests (base+1 .. base+PREF_DEGREE lines) and buffers them in a drop-oldest FIFO toward the icache request arbiter. Adds a configurable degree, back-to-back duplicate suppression, enable/flush controls, a drop counter and occupancy reporting. Sits between MSHR miss reporting and the icache prefetch request port.

---
 rtl/icache_stream_prefetcher_if.sv | 41 ++++
 rtl/icache_stream_prefetcher.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/icache_stream_prefetcher_if.sv
// Miss-report and prefetch-request channels of the icache stream prefetcher.
// master = prefetch engine side, slave = MSHR / request arbiter side.
interface icache_stream_prefetcher_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int TXNID_WIDTH = 8
);
    logic                   miss_vld;
    logic [ADDR_WIDTH-1:0]  miss_addr;
    logic [TXNID_WIDTH-1:0] miss_txnid;
    logic                   miss_rdy;

    logic                   pref_req_vld;
    logic [ADDR_WIDTH-1:0]  pref_req_addr;
    logic [TXNID_WIDTH-1:0] pref_req_txnid;
    logic [7:0]             pref_req_opcode;
    logic                   pref_req_rdy;

    modport master (
        input  miss_vld,
        input  miss_addr,
        input  miss_txnid,
        output miss_rdy,
        output pref_req_vld,
        output pref_req_addr,
        output pref_req_txnid,
        output pref_req_opcode,
        input  pref_req_rdy
    );

    modport slave (
        output miss_vld,
        output miss_addr,
        output miss_txnid,
        input  miss_rdy,
        input  pref_req_vld,
        input  pref_req_addr,
        input  pref_req_txnid,
        input  pref_req_opcode,
        output pref_req_rdy
    );
endinterface

// File: rtl/icache_stream_prefetcher.sv
// Next-line stream prefetcher: each accepted miss spawns PREF_DEGREE
// sequential line prefetches, buffered in a drop-oldest FIFO.
module icache_stream_prefetcher #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TXNID_WIDTH    = 8,
    parameter int LINE_BYTES     = 64,
    parameter int PREF_DEGREE    = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int PREF_OPCODE    = 1,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pf_en,
    input  logic                            pf_flush,
    icache_stream_prefetcher_if.master      bus,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy,
    output logic [DROP_CNT_WIDTH-1:0]       drop_cnt
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int K_W   = $clog2(PREF_DEGREE + 1);

    typedef enum logic { IDLE, GEN } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [TXNID_WIDTH-1:0]  txnid_q, txnid_d;
    logic [K_W-1:0]          k_q, k_d;
    logic                    tag_vld_q, tag_vld_d;
    logic [ADDR_WIDTH-1:0]   tag_q, tag_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    logic [ADDR_WIDTH-1:0]   mem_addr_q  [FIFO_DEPTH];
    logic [TXNID_WIDTH-1:0]  mem_txnid_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0]   cand;
    logic [PTR_W-1:0]        occ;
    logic                    empty;
    logic                    full;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    overwrite;
    logic [IDX_W-1:0]        rd_idx;

    // Flush and reset both block miss acceptance combinationally.
    assign bus.miss_rdy = rst_n && !pf_flush && (state_q == IDLE);

    // Candidate generation, FIFO bookkeeping and next-state selection.
    always_comb begin
        cand      = base_q + (ADDR_WIDTH'(k_q) << OFF_W);
        occ       = wr_ptr_q - rd_ptr_q;
        empty     = (occ == '0);
        full      = (occ == PTR_W'(FIFO_DEPTH));
        accept    = bus.miss_vld && bus.miss_rdy;
        push      = (state_q == GEN) && !(tag_vld_q && (cand == tag_q));
        pop       = !empty && bus.pref_req_rdy;
        overwrite = push && full && !pop;

        state_d   = state_q;
        base_d    = base_q;
        txnid_d   = txnid_q;
        k_d       = k_q;
        tag_vld_d = tag_vld_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        drop_d    = drop_q;

        unique case (state_q)
            IDLE: begin
                if (accept && pf_en) begin
                    base_d  = bus.miss_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
                    txnid_d = bus.miss_txnid;
                    k_d     = K_W'(1);
                    state_d = GEN;
                end
            end
            GEN: begin
                if (k_q == K_W'(PREF_DEGREE)) begin
                    state_d = IDLE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            tag_vld_d = 1'b1;
            tag_d     = cand;
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        end

        // A full FIFO without a pop loses its oldest entry to the new push.
        if (pop || overwrite) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (overwrite && (drop_q != '1)) begin
            drop_d = drop_q + DROP_CNT_WIDTH'(1);
        end

        if (pf_flush) begin
            state_d   = IDLE;
            tag_vld_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            txnid_q   <= '0;
            k_q       <= '0;
            tag_vld_q <= 1'b0;
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            txnid_q   <= txnid_d;
            k_q       <= k_d;
            tag_vld_q <= tag_vld_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            drop_q    <= drop_d;
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (rst_n && !pf_flush && push) begin
            mem_addr_q[wr_ptr_q[IDX_W-1:0]]  <= cand;
            mem_txnid_q[wr_ptr_q[IDX_W-1:0]] <= txnid_q;
        end
    end

    assign rd_idx              = rd_ptr_q[IDX_W-1:0];
    assign bus.pref_req_vld    = !empty;
    assign bus.pref_req_addr   = empty ? '0 : mem_addr_q[rd_idx];
    assign bus.pref_req_txnid  = empty ? '0 : mem_txnid_q[rd_idx];
    assign bus.pref_req_opcode = 8'(PREF_OPCODE);
    assign occupancy           = occ;
    assign drop_cnt            = drop_q;
endmodule
